iob_native_bus_split: RTL and testbench

//  Parametrised successor to the CPU bus splitter. Routes one native-interface master
//  (valid/addr/wdata/wstrb -> ready/rdata) to N_SLAVES slave ports.

---
 rtl/iob_native_bus_split_if.sv | 29 ++
 rtl/iob_native_bus_split.sv | 88 ++++++++
 tb/tb_iob_native_bus_split.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/iob_native_bus_split_if.sv
// iob_native_bus_split_if: master-side native bus plus flattened per-slave buses of the splitter
interface iob_native_bus_split_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int N_SLAVES = 4
);
  logic m_valid;
  logic m_instr;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W/8-1:0] m_wstrb;
  logic m_ready;
  logic [DATA_W-1:0] m_rdata;
  logic m_err;
  logic [N_SLAVES-1:0] s_valid;
  logic [N_SLAVES*ADDR_W-1:0] s_addr;
  logic [N_SLAVES*DATA_W-1:0] s_wdata;
  logic [N_SLAVES*DATA_W/8-1:0] s_wstrb;
  logic [N_SLAVES-1:0] s_ready;
  logic [N_SLAVES*DATA_W-1:0] s_rdata;
  modport master (
    output m_valid, m_instr, m_addr, m_wdata, m_wstrb, s_ready, s_rdata,
    input m_ready, m_rdata, m_err, s_valid, s_addr, s_wdata, s_wstrb
  );
  modport slave (
    input m_valid, m_instr, m_addr, m_wdata, m_wstrb, s_ready, s_rdata,
    output m_ready, m_rdata, m_err, s_valid, s_addr, s_wdata, s_wstrb
  );
endinterface

// File: rtl/iob_native_bus_split.sv
// iob_native_bus_split: registered one-master to N-slave native bus splitter with error responses
module iob_native_bus_split #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int N_SLAVES = 4,
  parameter int SEL_W = 2,
  parameter int MODE = 0,
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic resetn,
  iob_native_bus_split_if.slave bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam int TGT_W = SEL_W + 1;
  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2;
  logic [1:0] state;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q, s_rdata_sel;
  logic [STRB_W-1:0] wstrb_q;
  logic [15:0] cnt;
  logic err_q;
  logic [N_SLAVES-1:0] s_valid_q;
  logic [TGT_W-1:0] sel, tgt;
  logic hit, timed_out;
  // one extra target bit so that sel+1 in MODE 1 can land past the last slave
  assign sel = TGT_W'(bus.m_addr[ADDR_W-1 -: SEL_W]);
  assign tgt = MODE != 0 ? (bus.m_instr ? '0 : sel + TGT_W'(1)) : sel;
  assign hit = |(bus.s_ready & s_valid_q);
  assign timed_out = TIMEOUT != 0 && cnt == 16'(TIMEOUT - 1);
  always_comb begin
    s_rdata_sel = '0;
    for (int k = 0; k < N_SLAVES; k++) s_rdata_sel |= s_valid_q[k] ? bus.s_rdata[k*DATA_W +: DATA_W] : '0;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
      cnt <= '0;
      s_valid_q <= '0;
    end else if (state == IDLE && bus.m_valid) begin
      addr_q <= bus.m_addr;
      wdata_q <= bus.m_wdata;
      wstrb_q <= bus.m_wstrb;
      cnt <= '0;
      if (32'(tgt) < N_SLAVES) begin
        state <= BUSY;
        s_valid_q <= N_SLAVES'(1) << tgt;
      end else begin
        state <= RESP;
        err_q <= 1'b1;
        rdata_q <= '0;
      end
    end else if (state == BUSY) begin
      if (hit) begin
        state <= RESP;
        s_valid_q <= '0;
        rdata_q <= s_rdata_sel;
        err_q <= 1'b0;
      end else if (timed_out) begin
        state <= RESP;
        s_valid_q <= '0;
        rdata_q <= '0;
        err_q <= 1'b1;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end else if (state == RESP) begin
      state <= IDLE;
      rdata_q <= '0;
      err_q <= 1'b0;
    end
  end
  assign bus.m_ready = state == RESP;
  assign bus.m_rdata = rdata_q;
  assign bus.m_err = err_q;
  assign bus.s_valid = s_valid_q;
  // only the addressed slave sees the request; every other slice reads as zero
  for (genvar i = 0; i < N_SLAVES; i++) begin : g_slice
    assign bus.s_addr[i*ADDR_W +: ADDR_W] = s_valid_q[i] ? addr_q : '0;
    assign bus.s_wdata[i*DATA_W +: DATA_W] = s_valid_q[i] ? wdata_q : '0;
    assign bus.s_wstrb[i*STRB_W +: STRB_W] = s_valid_q[i] ? wstrb_q : '0;
  end
endmodule

// File: tb/tb_iob_native_bus_split.sv
// tb_iob_native_bus_split: three splitter configurations checked against a transaction-level model
module tb_iob_native_bus_split;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int checks = 0, errors = 0, last_rdy = 0;
  logic m_valid [3], m_instr [3];
  logic [31:0] m_addr [3], m_wdata [3];
  logic [3:0] m_wstrb [3], s_ready [3];
  logic [127:0] s_rdata [3];
  logic m_ready_o [3], m_err_o [3];
  logic [31:0] m_rdata_o [3];
  logic [3:0] s_valid_o [3];
  logic [127:0] s_addr_o [3], s_wdata_o [3];
  logic [15:0] s_wstrb_o [3];
  // a: MODE0/N4/TIMEOUT8, b: MODE1/N4/TIMEOUT8, c: MODE0/N3/TIMEOUT255
  iob_native_bus_split_if #(.N_SLAVES(4)) if_a ();
  iob_native_bus_split_if #(.N_SLAVES(4)) if_b ();
  iob_native_bus_split_if #(.N_SLAVES(3)) if_c ();
  iob_native_bus_split #(.MODE(0), .TIMEOUT(8)) u_a (.clk(clk), .resetn(resetn), .bus(if_a));
  iob_native_bus_split #(.MODE(1), .TIMEOUT(8)) u_b (.clk(clk), .resetn(resetn), .bus(if_b));
  iob_native_bus_split #(.N_SLAVES(3)) u_c (.clk(clk), .resetn(resetn), .bus(if_c));
  assign if_a.m_valid = m_valid[0];
  assign if_a.m_instr = m_instr[0];
  assign if_a.m_addr = m_addr[0];
  assign if_a.m_wdata = m_wdata[0];
  assign if_a.m_wstrb = m_wstrb[0];
  assign if_a.s_ready = s_ready[0];
  assign if_a.s_rdata = s_rdata[0];
  assign m_ready_o[0] = if_a.m_ready;
  assign m_err_o[0] = if_a.m_err;
  assign m_rdata_o[0] = if_a.m_rdata;
  assign s_valid_o[0] = if_a.s_valid;
  assign s_addr_o[0] = if_a.s_addr;
  assign s_wdata_o[0] = if_a.s_wdata;
  assign s_wstrb_o[0] = if_a.s_wstrb;
  assign if_b.m_valid = m_valid[1];
  assign if_b.m_instr = m_instr[1];
  assign if_b.m_addr = m_addr[1];
  assign if_b.m_wdata = m_wdata[1];
  assign if_b.m_wstrb = m_wstrb[1];
  assign if_b.s_ready = s_ready[1];
  assign if_b.s_rdata = s_rdata[1];
  assign m_ready_o[1] = if_b.m_ready;
  assign m_err_o[1] = if_b.m_err;
  assign m_rdata_o[1] = if_b.m_rdata;
  assign s_valid_o[1] = if_b.s_valid;
  assign s_addr_o[1] = if_b.s_addr;
  assign s_wdata_o[1] = if_b.s_wdata;
  assign s_wstrb_o[1] = if_b.s_wstrb;
  assign if_c.m_valid = m_valid[2];
  assign if_c.m_instr = m_instr[2];
  assign if_c.m_addr = m_addr[2];
  assign if_c.m_wdata = m_wdata[2];
  assign if_c.m_wstrb = m_wstrb[2];
  assign if_c.s_ready = s_ready[2][2:0];
  assign if_c.s_rdata = s_rdata[2][95:0];
  assign m_ready_o[2] = if_c.m_ready;
  assign m_err_o[2] = if_c.m_err;
  assign m_rdata_o[2] = if_c.m_rdata;
  assign s_valid_o[2] = {1'b0, if_c.s_valid};
  assign s_addr_o[2] = {32'h0, if_c.s_addr};
  assign s_wdata_o[2] = {32'h0, if_c.s_wdata};
  assign s_wstrb_o[2] = {4'h0, if_c.s_wstrb};

  typedef struct {
    int k;
    logic instr;
    logic [31:0] addr;
    logic [3:0] wstrb;
    int d;
    logic [3:0] ov;
    bit err;
    int lat;
    int busy;
  } vec_t;
  vec_t tbl [10];
  int r [3];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] flat(input logic [3:0] ov, input logic [31:0] v, input int w);
    logic [127:0] res = '0;
    for (int j = 0; j < 4; j++) if (ov[j]) res = res | (128'(v) << (j * w));
    return res;
  endfunction

  // transaction-level expectation: which slave, error, response latency, cycles s_valid is high
  task automatic model(input int k, input logic instr, input logic [31:0] addr, input int d,
                       output logic [3:0] ov, output bit err, output int lat, output int busy);
    int n = k == 2 ? 3 : 4;
    int to = k == 2 ? 255 : 8;
    int sel = int'(addr[31:30]);
    int tgt = k == 1 ? (instr ? 0 : sel + 1) : sel;
    if (tgt >= n) begin
      ov = 4'h0; err = 1'b1; lat = 1; busy = 0;
    end else if (d < to) begin
      ov = 4'(1 << tgt); err = 1'b0; lat = d + 2; busy = d + 1;
    end else begin
      ov = 4'(1 << tgt); err = 1'b1; lat = to + 1; busy = to;
    end
  endtask

  // d = index of the BUSY cycle in which the target raises s_ready (large = never)
  task automatic run_txn(input int k, input logic instr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input int d, input logic [3:0] ov, input bit err,
                         input int lat, input int busy, input string tag);
    int got = 0, nb = 0;
    bit first = 1'b1;
    logic [31:0] rd = '0, exp_rd = '0;
    logic er = 1'b0;
    @(negedge clk);
    m_valid[k] = 1'b1; m_instr[k] = instr; m_addr[k] = addr; m_wdata[k] = wdata; m_wstrb[k] = wstrb;
    for (int c = 1; c <= lat + 4; c++) begin
      @(negedge clk);
      if (s_valid_o[k] != 4'h0) begin
        nb++;
        if (first) begin
          first = 1'b0;
          check({tag, " s_valid"}, 128'(s_valid_o[k]), 128'(ov));
          check({tag, " s_addr"}, s_addr_o[k], flat(ov, addr, 32));
          check({tag, " s_wdata"}, s_wdata_o[k], flat(ov, wdata, 32));
          check({tag, " s_wstrb"}, 128'(s_wstrb_o[k]), flat(ov, 32'(wstrb), 4));
        end
      end
      if (m_ready_o[k]) begin
        got = c; rd = m_rdata_o[k]; er = m_err_o[k];
        break;
      end
      s_ready[k] = (c - 1 == d ? ov : 4'h0) | (4'($urandom) & ~ov);
    end
    s_ready[k] = 4'h0;
    m_valid[k] = 1'b0;
    last_rdy = cyc;
    for (int j = 0; j < 4; j++) if (ov[j] && !err) exp_rd = s_rdata[k][j*32 +: 32];
    check({tag, " latency"}, 128'(got), 128'(lat));
    check({tag, " m_err"}, 128'(er), 128'(err));
    check({tag, " m_rdata"}, 128'(rd), 128'(exp_rd));
    check({tag, " busy cycles"}, 128'(nb), 128'(busy));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      m_valid[k] = 0; m_instr[k] = 0; m_addr[k] = 0; m_wdata[k] = 0; m_wstrb[k] = 0; s_ready[k] = 0;
    end
    s_rdata[0] = {32'h3333_3333, 32'h2222_2222, 32'hCAFE_F00D, 32'h1111_1111};
    s_rdata[1] = {32'hB3B3_B3B3, 32'hB2B2_B2B2, 32'hB1B1_B1B1, 32'hB0B0_B0B0};
    s_rdata[2] = {32'h0, 32'hC2C2_C2C2, 32'hC1C1_C1C1, 32'hC0C0_C0C0};
    tbl[0] = '{0, 1'b0, 32'h4000_0010, 4'h0, 0, 4'b0010, 1'b0, 2, 1};
    tbl[1] = '{1, 1'b1, 32'hC000_0000, 4'h0, 0, 4'b0001, 1'b0, 2, 1};
    tbl[2] = '{1, 1'b0, 32'h4000_0004, 4'b0011, 0, 4'b0100, 1'b0, 2, 1};
    tbl[3] = '{1, 1'b0, 32'hC000_0000, 4'h0, 0, 4'b0000, 1'b1, 1, 0};
    tbl[4] = '{2, 1'b0, 32'hC000_0000, 4'h0, 0, 4'b0000, 1'b1, 1, 0};
    tbl[5] = '{0, 1'b0, 32'hC000_0000, 4'h0, 100, 4'b1000, 1'b1, 9, 8};
    tbl[6] = '{0, 1'b0, 32'h8000_0000, 4'hF, 7, 4'b0100, 1'b0, 9, 8};
    tbl[7] = '{0, 1'b0, 32'h0000_0040, 4'h1, 3, 4'b0001, 1'b0, 5, 4};
    tbl[8] = '{2, 1'b0, 32'h8000_0008, 4'h0, 2, 4'b0100, 1'b0, 4, 3};
    tbl[9] = '{0, 1'b1, 32'h4000_0020, 4'h0, 0, 4'b0010, 1'b0, 2, 1};
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset m_ready %0d", k), 128'(m_ready_o[k]), 128'(0));
      check($sformatf("reset m_err %0d", k), 128'(m_err_o[k]), 128'(0));
      check($sformatf("reset m_rdata %0d", k), 128'(m_rdata_o[k]), 128'(0));
      check($sformatf("reset s_valid %0d", k), 128'(s_valid_o[k]), 128'(0));
      check($sformatf("reset s_addr %0d", k), s_addr_o[k], 128'(0));
    end
    resetn = 1'b1;
    for (int i = 0; i < 10; i++)
      run_txn(tbl[i].k, tbl[i].instr, tbl[i].addr, 32'hD000_0000 + 32'(i), tbl[i].wstrb, tbl[i].d,
              tbl[i].ov, tbl[i].err, tbl[i].lat, tbl[i].busy, $sformatf("vec%0d", i));
    // s_ready arriving after a timeout must not produce a second response
    run_txn(0, 1'b0, 32'hC000_0004, 32'h0, 4'h0, 100, 4'b1000, 1'b1, 9, 8, "timeout");
    @(negedge clk);
    s_ready[0] = 4'b1000;
    @(negedge clk);
    check("late ready m_ready", 128'(m_ready_o[0]), 128'(0));
    check("late ready s_valid", 128'(s_valid_o[0]), 128'(0));
    s_ready[0] = 4'h0;
    run_txn(0, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 0, 4'b0001, 1'b0, 2, 1, "b2b0");
    r[0] = last_rdy;
    run_txn(0, 1'b0, 32'h4000_0200, 32'h0, 4'h0, 0, 4'b0010, 1'b0, 2, 1, "b2b1");
    r[1] = last_rdy;
    run_txn(0, 1'b0, 32'h8000_0300, 32'h0, 4'h0, 0, 4'b0100, 1'b0, 2, 1, "b2b2");
    r[2] = last_rdy;
    check("b2b spacing 1", 128'(r[1] - r[0]), 128'(3));
    check("b2b spacing 2", 128'(r[2] - r[1]), 128'(3));
    // asynchronous reset in the second BUSY cycle aborts without a response
    @(negedge clk);
    m_valid[0] = 1'b1; m_addr[0] = 32'h4000_0000; m_wstrb[0] = 4'h0;
    repeat (2) @(negedge clk);
    check("pre-reset s_valid", 128'(s_valid_o[0]), 128'(4'b0010));
    #2 resetn = 1'b0;
    #1;
    check("abort s_valid", 128'(s_valid_o[0]), 128'(0));
    check("abort m_ready", 128'(m_ready_o[0]), 128'(0));
    m_valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    check("abort no m_ready", 128'(m_ready_o[0]), 128'(0));
    resetn = 1'b1;
    run_txn(0, 1'b0, 32'h4000_0010, 32'h0, 4'h0, 1, 4'b0010, 1'b0, 3, 2, "post-reset");
    for (int i = 0; i < 60; i++) begin
      int k, d, lat, busy;
      logic instr;
      logic [31:0] addr, wdata;
      logic [3:0] wstrb, ov;
      bit err;
      k = $urandom_range(0, 2);
      instr = 1'($urandom);
      addr = $urandom;
      wdata = $urandom;
      wstrb = 4'($urandom);
      d = $urandom_range(0, 4) == 0 ? 9 : $urandom_range(0, 3);
      s_rdata[k] = {$urandom, $urandom, $urandom, $urandom};
      if (k == 2) s_rdata[2][127:96] = 32'h0;
      model(k, instr, addr, d, ov, err, lat, busy);
      run_txn(k, instr, addr, wdata, wstrb, d, ov, err, lat, busy, $sformatf("rnd%0d", i));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
